// File: rtl/pong_match_ctrl.sv
// Pong match sequencer: scores, serve countdown, post-point freeze and game-over.
// Gates the ball engine through ball_enable / ball_reset from miss pulses and frame ticks.
module pong_match_ctrl #(
  parameter int unsigned WIN_SCORE    = 9,
  parameter int unsigned SERVE_FRAMES = 60,
  parameter int unsigned POINT_FRAMES = 90
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       frame_tick,
  input  logic       start,
  input  logic       miss_l,
  input  logic       miss_r,
  output logic       ball_enable,
  output logic       ball_reset,
  output logic       serve_dir,
  output logic [3:0] score_l,
  output logic [3:0] score_r,
  output logic       game_over,
  output logic       winner,
  output logic [2:0] state_o
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_SERVE = 3'd1,
    S_PLAY  = 3'd2,
    S_POINT = 3'd3,
    S_OVER  = 3'd4
  } state_e;

  localparam logic [3:0] WIN_LD   = 4'(WIN_SCORE);
  localparam logic [7:0] SERVE_LD = 8'(SERVE_FRAMES);
  localparam logic [7:0] POINT_LD = 8'(POINT_FRAMES);

  state_e     state_q, state_d;
  logic [7:0] cnt_q, cnt_d;
  logic [3:0] score_l_q, score_l_d;
  logic [3:0] score_r_q, score_r_d;
  logic       serve_dir_q, serve_dir_d;
  logic       winner_q, winner_d;
  logic       ball_reset_q, ball_reset_d;
  logic       ball_enable_q;
  logic       game_over_q;

  logic [3:0] score_l_inc;
  logic [3:0] score_r_inc;

  assign score_l_inc = score_l_q + 4'd1;
  assign score_r_inc = score_r_q + 4'd1;

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    score_l_d    = score_l_q;
    score_r_d    = score_r_q;
    serve_dir_d  = serve_dir_q;
    winner_d     = winner_q;
    ball_reset_d = 1'b0;

    case (state_q)
      S_IDLE, S_OVER: begin
        if (start) begin
          score_l_d    = 4'd0;
          score_r_d    = 4'd0;
          serve_dir_d  = 1'b1;
          winner_d     = 1'b0;
          cnt_d        = SERVE_LD;
          ball_reset_d = 1'b1;
          state_d      = S_SERVE;
        end
      end

      S_SERVE: begin
        if (frame_tick) begin
          cnt_d = cnt_q - 8'd1;
          if (cnt_q <= 8'd1) begin
            state_d = S_PLAY;
          end
        end
      end

      S_PLAY: begin
        // A double miss is treated as a void rally: re-serve with no score.
        if (miss_l && miss_r) begin
          cnt_d        = SERVE_LD;
          ball_reset_d = 1'b1;
          state_d      = S_SERVE;
        end else if (miss_r) begin
          serve_dir_d = 1'b1;
          if (score_l_q < WIN_LD) begin
            score_l_d = score_l_inc;
          end
          if (score_l_inc >= WIN_LD) begin
            winner_d = 1'b0;
            state_d  = S_OVER;
          end else begin
            cnt_d   = POINT_LD;
            state_d = S_POINT;
          end
        end else if (miss_l) begin
          serve_dir_d = 1'b0;
          if (score_r_q < WIN_LD) begin
            score_r_d = score_r_inc;
          end
          if (score_r_inc >= WIN_LD) begin
            winner_d = 1'b1;
            state_d  = S_OVER;
          end else begin
            cnt_d   = POINT_LD;
            state_d = S_POINT;
          end
        end
      end

      S_POINT: begin
        if (frame_tick) begin
          if (cnt_q <= 8'd1) begin
            cnt_d        = SERVE_LD;
            ball_reset_d = 1'b1;
            state_d      = S_SERVE;
          end else begin
            cnt_d = cnt_q - 8'd1;
          end
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Outputs are registered from the next state so they line up with the state they describe.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= S_IDLE;
      cnt_q         <= 8'd0;
      score_l_q     <= 4'd0;
      score_r_q     <= 4'd0;
      serve_dir_q   <= 1'b1;
      winner_q      <= 1'b0;
      ball_reset_q  <= 1'b0;
      ball_enable_q <= 1'b0;
      game_over_q   <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      score_l_q     <= score_l_d;
      score_r_q     <= score_r_d;
      serve_dir_q   <= serve_dir_d;
      winner_q      <= winner_d;
      ball_reset_q  <= ball_reset_d;
      ball_enable_q <= (state_d == S_PLAY);
      game_over_q   <= (state_d == S_OVER);
    end
  end

  assign ball_enable = ball_enable_q;
  assign ball_reset  = ball_reset_q;
  assign serve_dir   = serve_dir_q;
  assign score_l     = score_l_q;
  assign score_r     = score_r_q;
  assign game_over   = game_over_q;
  assign winner      = winner_q;
  assign state_o     = state_q;

endmodule
